// File: rtl/ldpc_llr_packer.sv
// Serial-to-parallel LLR packer: gathers Z consecutive WIDTH-bit LLRs into one
// lane word and tags each word with its position inside the codeword.
module ldpc_llr_packer #(
    parameter  int WIDTH  = 8,
    parameter  int Z      = 8,
    parameter  int BLOCKS = 24,
    localparam int LANE_W = $clog2(Z),
    localparam int BLK_W  = (BLOCKS > 1) ? $clog2(BLOCKS) : 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_flush,
    input  logic [WIDTH-1:0]     i_in_data,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    output logic [WIDTH*Z-1:0]   o_out_data,
    output logic                 o_out_valid,
    output logic                 o_out_last,
    output logic [BLK_W-1:0]     o_block_index,
    input  logic                 i_out_ready
);

    localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(Z - 1);
    localparam logic [BLK_W-1:0]  BLK_LAST  = BLK_W'(BLOCKS - 1);

    logic [LANE_W-1:0]  lane_q, lane_d;
    logic [BLK_W-1:0]   blk_q, blk_d;
    logic               acc_full_q, acc_full_d;
    logic               run_q;
    logic [WIDTH*Z-1:0] acc_q, acc_d;
    logic [WIDTH*Z-1:0] out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [BLK_W-1:0]   idx_q, idx_d;

    logic               in_fire;
    logic               out_free;
    logic               load;
    logic [WIDTH*Z-1:0] load_word;
    logic [Z-1:0]       lane_sel;

    // run_q keeps the input closed while reset is held and until the first edge after it.
    assign o_in_ready = run_q & ~acc_full_q & ~i_flush;
    assign in_fire    = i_in_valid & o_in_ready;
    assign out_free   = ~out_valid_q | i_out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < Z; gi++) begin : g_lane_sel
            assign lane_sel[gi] = (lane_q == LANE_W'(gi));
        end
    endgenerate

    always_comb begin
        lane_d      = lane_q;
        blk_d       = blk_q;
        acc_full_d  = acc_full_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        idx_d       = idx_q;
        load        = 1'b0;
        load_word   = acc_q;

        if (in_fire) begin
            for (int k = 0; k < Z; k++) begin
                if (lane_sel[k]) begin
                    acc_d[k*WIDTH +: WIDTH] = i_in_data;
                end
            end
            lane_d = (lane_q == LANE_LAST) ? '0 : lane_q + LANE_W'(1);
        end

        // A held word always goes first; input is closed while it waits.
        if (acc_full_q) begin
            if (out_free) begin
                load       = 1'b1;
                load_word  = acc_q;
                acc_full_d = 1'b0;
            end
        end else if (in_fire && lane_q == LANE_LAST) begin
            if (out_free) begin
                load      = 1'b1;
                load_word = acc_d;
            end else begin
                acc_full_d = 1'b1;
            end
        end

        if (load) begin
            out_data_d  = load_word;
            out_valid_d = 1'b1;
            idx_d       = blk_q;
            out_last_d  = (blk_q == BLK_LAST);
            blk_d       = (blk_q == BLK_LAST) ? '0 : blk_q + BLK_W'(1);
        end else if (i_out_ready) begin
            out_valid_d = 1'b0;
        end

        if (i_flush) begin
            lane_d      = '0;
            blk_d       = '0;
            acc_full_d  = 1'b0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            idx_d       = '0;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            lane_q      <= '0;
            blk_q       <= '0;
            acc_full_q  <= 1'b0;
            run_q       <= 1'b0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            idx_q       <= '0;
        end else begin
            lane_q      <= lane_d;
            blk_q       <= blk_d;
            acc_full_q  <= acc_full_d;
            run_q       <= 1'b1;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            idx_q       <= idx_d;
        end
    end

    assign o_out_data    = out_data_q;
    assign o_out_valid   = out_valid_q;
    assign o_out_last    = out_last_q;
    assign o_block_index = idx_q;

endmodule
